// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access pipeline stage between Ex2Mem and Mem2Wb.
// Issues loads/stores over a valid/ready request + response bus, aligns and
// extends load data, and holds the pipeline until the access completes.
// Non-memory instructions pass through combinationally.
// Optional feature macro: MEM_MISALIGN_CHECK_EN
//   defined   -> misaligned half/word/double accesses trap (cause 4 load, 6 store)
//   undefined -> address bits below the access size are forced to zero
module mem_access_stage #(
    parameter int DATA_W  = 64,
    parameter int RADDR_W = 5
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               FlushIn,
    input  logic               MemReadIn,
    input  logic               MemWriteIn,
    input  logic [1:0]         MemSizeIn,
    input  logic               MemUnsignedIn,
    input  logic [DATA_W-1:0]  MemAddrIn,
    input  logic [DATA_W-1:0]  MemWDataIn,
    input  logic [DATA_W-1:0]  RdWriteDataIn,
    input  logic [RADDR_W-1:0] RdAddrIn,
    input  logic               RdWriteEnableIn,
    input  logic [DATA_W-1:0]  InstAddrIn,
    input  logic [DATA_W-1:0]  ExcInfoIn,
    output logic               DReqValid,
    input  logic               DReqReady,
    output logic               DReqWrite,
    output logic [DATA_W-1:0]  DReqAddr,
    output logic [DATA_W-1:0]  DReqWData,
    output logic [7:0]         DReqStrb,
    input  logic               DRspValid,
    input  logic [DATA_W-1:0]  DRspData,
    output logic               HoldReq,
    output logic [DATA_W-1:0]  RdWriteDataOut,
    output logic [RADDR_W-1:0] RdAddrOut,
    output logic               RdWriteEnableOut,
    output logic [DATA_W-1:0]  InstAddrOut,
    output logic [DATA_W-1:0]  ExcInfoOut
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] loadbuf_q, loadbuf_d;

    // Address bits that must be zero for a naturally aligned access of this size.
    function automatic logic [2:0] low_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    // Byte strobes for a lane-0 access of this size.
    function automatic logic [7:0] strb_base(input logic [1:0] size);
        case (size)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Pick the addressed lane out of the doubleword and sign/zero-extend it.
    function automatic logic [DATA_W-1:0] load_extend(
        input logic [DATA_W-1:0] raw,
        input logic [2:0]        lane,
        input logic [1:0]        size,
        input logic              uns
    );
        logic [DATA_W-1:0]  sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] w;
        sh = raw >> {lane, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        w  = sh[31:0];
        case (size)
            2'd0:    return uns ? {{(DATA_W-8){1'b0}}, b}  : {{(DATA_W-8){b[7]}}, b};
            2'd1:    return uns ? {{(DATA_W-16){1'b0}}, h} : {{(DATA_W-16){h[15]}}, h};
            2'd2:    return uns ? {{(DATA_W-32){1'b0}}, w} : {{(DATA_W-32){w[31]}}, w};
            default: return sh;
        endcase
    endfunction

    logic              mem_op;
    logic              aligned;
    logic              mis_trap;
    logic              acc;
    logic [2:0]        eff_lane;
    logic [DATA_W-1:0] mis_exc;

    // Access qualification: alignment handling depends on the misalign-check build.
    always_comb begin
        mem_op = MemReadIn | MemWriteIn;
`ifdef MEM_MISALIGN_CHECK_EN
        eff_lane = MemAddrIn[2:0];
        aligned  = ~|(MemAddrIn[2:0] & low_mask(MemSizeIn));
`else
        eff_lane = MemAddrIn[2:0] & ~low_mask(MemSizeIn);
        aligned  = 1'b1;
`endif
        mis_trap = mem_op & ~ExcInfoIn[15] & ~aligned;
        acc      = mem_op & ~ExcInfoIn[15] & ~FlushIn & aligned;
        mis_exc  = {{(DATA_W-16){1'b0}}, 1'b1, 8'h00, (MemWriteIn ? 7'd6 : 7'd4)};
    end

    // Next-state and output logic; outputs are forced to zero while in reset.
    always_comb begin
        state_d          = state_q;
        loadbuf_d        = loadbuf_q;
        DReqValid        = 1'b0;
        HoldReq          = 1'b0;
        DReqWrite        = 1'b0;
        DReqAddr         = '0;
        DReqWData        = '0;
        DReqStrb         = '0;
        RdWriteDataOut   = '0;
        RdAddrOut        = '0;
        RdWriteEnableOut = 1'b0;
        InstAddrOut      = '0;
        ExcInfoOut       = '0;
        if (!Rst) begin
            DReqWrite      = MemWriteIn;
            DReqAddr       = {MemAddrIn[DATA_W-1:3], 3'b000};
            DReqWData      = MemWDataIn << {eff_lane, 3'b000};
            DReqStrb       = strb_base(MemSizeIn) << eff_lane;
            RdWriteDataOut = RdWriteDataIn;
            RdAddrOut      = RdAddrIn;
            InstAddrOut    = InstAddrIn;
            ExcInfoOut     = mis_trap ? mis_exc : ExcInfoIn;
            // Memory ops only write back from DONE; everything else passes now.
            RdWriteEnableOut = RdWriteEnableIn & ~FlushIn & ~ExcInfoIn[15] & ~mem_op;
            unique case (state_q)
                IDLE: begin
                    if (acc) begin
                        DReqValid = 1'b1;
                        HoldReq   = 1'b1;
                        if (DReqReady) state_d = WAIT;
                    end
                end
                WAIT: begin
                    HoldReq = 1'b1;
                    if (DRspValid) begin
                        // A flush coinciding with the response just drops the data.
                        if (FlushIn) begin
                            state_d = IDLE;
                        end else begin
                            loadbuf_d = DRspData;
                            state_d   = DONE;
                        end
                    end else if (FlushIn) begin
                        state_d = DRAIN;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    if (MemReadIn) begin
                        RdWriteDataOut = load_extend(loadbuf_q, eff_lane, MemSizeIn, MemUnsignedIn);
                    end
                    RdWriteEnableOut = MemReadIn & RdWriteEnableIn & ~FlushIn;
                end
                DRAIN: begin
                    HoldReq = acc;
                    if (DRspValid) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and load buffer registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= IDLE;
            loadbuf_q <= '0;
        end else begin
            state_q   <= state_d;
            loadbuf_q <= loadbuf_d;
        end
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access pipeline stage sitting between the Ex2Mem and Mem2Wb pipeline registers. It issues loads/stores to the data bus through a valid/ready request and response handshake. It aligns and extends load data, detects misaligned accesses and holds the pipeline until the access completes. Non-memory instructions pass through combinationally to Mem2Wb.

## Interface
Parameters:
- DATA_W, 64, data and address width
- RADDR_W, 5, register-file address width

Ports:
- Clk  in  1  clock, all state on rising edge
- Rst  in  1  synchronous, active-high reset
- FlushIn  in  1  pipeline flush from Ctrl (trap/redirect)
- MemReadIn / MemWriteIn  in  1 each  instruction is a load / store (never both)
- MemSizeIn  in  2  0=byte, 1=half, 2=word, 3=double
- MemUnsignedIn  in  1  zero-extend load
- MemAddrIn  in  DATA_W  effective address
- MemWDataIn  in  DATA_W  store data, LSB-aligned
- RdWriteDataIn / RdAddrIn / RdWriteEnableIn  in  DATA_W / RADDR_W / 1  ALU result and destination
- InstAddrIn  in  DATA_W  PC
- ExcInfoIn  in  DATA_W  bit15 = exception flag, [6:0] = cause
- DReqValid  out  1  bus request valid
- DReqReady  in  1  bus accepts request
- DReqWrite  out  1  1 = store
- DReqAddr  out  DATA_W  address with [2:0] cleared
- DReqWData  out  DATA_W  lane-shifted store data
- DReqStrb  out  8  byte strobes
- DRspValid  in  1  response valid (load data or store ack)
- DRspData  in  DATA_W  doubleword read data
- HoldReq  out  1  stall request to Ctrl
- RdWriteDataOut / RdAddrOut / RdWriteEnableOut / InstAddrOut / ExcInfoOut  out  to Mem2Wb

## Operation
- FSM states: IDLE, WAIT, DONE, DRAIN.
- Access condition (`acc`): (MemReadIn | MemWriteIn) & !ExcInfoIn[15] & !FlushIn & aligned.
- IDLE:
  - If `acc`: DReqValid=1 and HoldReq=1, combinational from the inputs.
  - On DReqReady, go to WAIT. Otherwise stay in IDLE and keep the request stable.
  - If not `acc`: pass through, HoldReq=0.
- WAIT:
  - HoldReq=1, DReqValid=0.
  - On DRspValid: latch DRspData into LoadBuf and go to DONE.
  - If FlushIn is seen while waiting for the response, go to DRAIN instead of DONE.
- DONE:
  - HoldReq=0.
  - Outputs the registered result; Mem2Wb captures it this cycle.
  - Unconditionally returns to IDLE next cycle, with no new issue in DONE.
- DRAIN:
  - HoldReq=0, no request issued.
  - On DRspValid, discard the data and go to IDLE.
  - If a new access is pending in DRAIN, it waits; HoldReq=1 while that access is pending.
- Load result: lane = MemAddrIn[2:0]; shift DRspData right by lane×8, then take size bits and sign- or zero-extend. A double-size load ignores MemUnsignedIn.
- Store: DReqWData = MemWDataIn << lane×8; DReqStrb = size mask (0x01/0x03/0x0F/0xFF) << lane.
- Stores return RdWriteEnableOut=0. Loads output RdWriteDataOut = load result.
- Misaligned: half with addr[0]≠0, word with addr[1:0]≠0, double with addr[2:0]≠0.
  - No bus request is issued.
  - ExcInfoOut = {bit15=1, cause 4 for load / 6 for store}.
  - RdWriteEnableOut=0.
- ExcInfoIn[15] set: no access; all fields pass through with RdWriteEnableOut=0.
- FlushIn in IDLE suppresses issue and forces RdWriteEnableOut=0.

## Timing
- Reset: state=IDLE, LoadBuf=0, and every output is 0 (DReqValid, HoldReq, DReqStrb, RdWriteEnableOut, data outputs).
- Non-memory op: 0-cycle combinational pass-through, no stall.
- Load, best case (DReqReady=1 in cycle 0, DRspValid in cycle 1): result valid in cycle 2 (DONE); HoldReq high in cycles 0–1.
- Each cycle DReqReady is low adds one cycle; each cycle of response delay adds one cycle.
- Inputs are stable while HoldReq=1, because Ctrl holds Ex2Mem.
- A response in the same cycle as request acceptance is illegal; the bus guarantees at least 1 cycle of latency.
- Rst mid-access forces IDLE. The bus side is reset by the same Rst, so no response is expected after it.

## Configuration
- MEM_MISALIGN_CHECK_EN:
  - Defined: misaligned accesses trap as described above.
  - Undefined: no check. Address bits below the access size are forced to zero and the access proceeds; ExcInfo is passed through unchanged.

## Test plan
- ALU op RdWriteDataIn=0x1234, RdAddrIn=5, RdWriteEnableIn=1 -> same values on outputs in the same cycle, HoldReq=0, DReqValid=0.
- LB with addr 0x1003, DRspData=0x00000000_80000000, ready immediately, response after 1 cycle -> DONE in cycle 2 with RdWriteDataOut=0xFFFFFFFF_FFFFFF80; with MemUnsignedIn=1 -> 0x80.
- SH with addr 0x2006, MemWDataIn=0xABCD -> DReqWData=0xABCD0000_00000000, DReqStrb=0xC0, DReqWrite=1; RdWriteEnableOut=0 in DONE.
- LW with addr 0x1002, macro defined -> no DReqValid, ExcInfoOut[15]=1 with cause 4, HoldReq=0; macro undefined -> request issued with DReqAddr=0x1000.
- DReqReady low for 3 cycles, then DRspValid 2 cycles after acceptance -> HoldReq high for exactly 6 cycles, request fields stable throughout.
- FlushIn asserted during WAIT -> DRAIN, response discarded, RdWriteEnableOut never 1 for that load, back in IDLE the cycle after DRspValid.
